// File: rtl/cyq_loader_pkg.sv
// Shared types and default constants for the operand loader.
package cyq_loader_pkg;

  // Loader FSM states; 2'b11 is unused and recovers to WAIT_A.
  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } cyq_state_t;

  // 20000 stable clocks is a few hundred microseconds at typical board clocks.
  localparam int DEB_CYCLES_DEFAULT = 20000;
  // Largest operand code accepted (decimal digit range).
  localparam int MAXCODE_DEFAULT    = 9;

endpackage

// File: rtl/cyq_operand_loader_if.sv
// Bundle of the loader's switch/button inputs and operand outputs.
//
// Handshake: there is no valid/ready pair. A and B are qualified by VALID,
// a level that is high exactly while both operands are loaded; while VALID=1
// the consumer may sample A/B on any cycle and they will not change until
// the edge that drops VALID. ERR and STATE are status levels.
interface cyq_operand_loader_if;
  logic [3:0] D;
  logic       KEY;
  logic [3:0] A;
  logic [3:0] B;
  logic       VALID;
  logic       ERR;
  logic [1:0] STATE;

  // Driver side: switches and button in, operands and status out.
  modport master (
    output D, KEY,
    input  A, B, VALID, ERR, STATE
  );

  // Loader side.
  modport slave (
    input  D, KEY,
    output A, B, VALID, ERR, STATE
  );
endinterface

// File: rtl/cyq_debounce.sv
// Push-button conditioner: 2-flop synchronizer, saturating stability
// counter and a single-cycle pulse on the debounced rising edge.
module cyq_debounce
  import cyq_loader_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic KEY,
  output logic PRESS
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEB_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          press_q, press_d;

  // Next-state: count consecutive clocks where the synchronized key differs
  // from the accepted level; any agreement restarts the count.
  always_comb begin
    sync1_d = KEY;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        // This clock completes DEB_CYCLES differing samples: accept it.
        level_d = sync2_q;
        cnt_d   = '0;
        press_d = sync2_q;   // pulse only on the 0->1 change
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign PRESS = press_q;

endmodule

// File: rtl/cyq_operand_loader.sv
// Two-operand loader: each debounced KEY press captures D into A, then B,
// then overwrites A (keeping B) so a new pair can be built. Codes above
// MAXCODE are rejected and flagged on ERR.
module cyq_operand_loader
  import cyq_loader_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int MAXCODE    = MAXCODE_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  cyq_operand_loader_if.slave   bus
);

  localparam logic [3:0] MAXCODE_4 = 4'(MAXCODE);

  logic       press;
  logic       code_ok;
  cyq_state_t state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;

  cyq_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .CLK   (CLK),
    .RST_N (RST_N),
    .KEY   (bus.KEY),
    .PRESS (press)
  );

  assign code_ok = (bus.D <= MAXCODE_4);

  // Next-state and operand capture; each press is consumed by one state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    case (state_q)
      WAIT_A: begin
        if (press && code_ok) begin
          a_d     = bus.D;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press && code_ok) begin
          b_d     = bus.D;
          state_d = READY;
        end
      end
      READY: begin
        if (press && code_ok) begin
          a_d     = bus.D;
          state_d = WAIT_B;
        end
      end
      default: state_d = WAIT_A;
    endcase
    if (press) begin
      err_d = !code_ok;
    end
    // Registered VALID tracks the state being entered.
    valid_d = (state_d == READY);
  end

  // FSM, operand and status registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= WAIT_A;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.VALID = valid_q;
  assign bus.ERR   = err_q;
  assign bus.STATE = state_q;

endmodule

// File: doc/cyq_operand_loader.md
CYQ_OPERAND_LOADER -- requirements
Module: cyq_operand_loader

Interface
REQ-001 Parameter DEB_CYCLES, default 20000: number of consecutive stable clocks needed to accept a new KEY level.
REQ-002 Parameter MAXCODE, default 9: the largest 4-bit operand code accepted.
REQ-003 CLK  input  1  sole clock; every flop is rising-edge on CLK.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 D  input  4  raw switch operand; static while KEY is pressed.
REQ-006 KEY  input  1  raw push button, active-high, asynchronous and bouncing.
REQ-007 A  output  4  registered first operand; feeds the downstream comparator A port.
REQ-008 B  output  4  registered second operand; feeds the downstream comparator B port.
REQ-009 VALID  output  1  high while A and B are both loaded and stable.
REQ-010 ERR  output  1  sticky flag: the last capture attempt was rejected.
REQ-011 STATE  output  2  current FSM state, for LEDs.

Function
REQ-012 KEY shall pass through a 2-flop synchronizer before any other logic.
REQ-013 The debounced level shall change only after the synchronized KEY has differed from it for DEB_CYCLES consecutive clocks; any bounce shall restart the count.
REQ-014 A 0-to-1 transition of the debounced level shall produce one single-cycle press pulse; the 1-to-0 transition shall produce no pulse.
REQ-015 The FSM shall have three states: WAIT_A=2'b00, WAIT_B=2'b01, READY=2'b10; 2'b11 is unreachable and shall recover to WAIT_A.
REQ-016 WAIT_A, on a press with D<=MAXCODE: A<=D, go to WAIT_B, ERR<=0.
REQ-017 WAIT_B, on a press with D<=MAXCODE: B<=D, go to READY, ERR<=0.
REQ-018 READY, on a press with D<=MAXCODE: A<=D, B is held, go to WAIT_B, ERR<=0.
REQ-019 On any press with D>MAXCODE: no operand is written, the state is unchanged, and ERR<=1.
REQ-020 VALID shall equal (STATE==READY) and be registered; it rises on the clock edge that writes B.
REQ-021 Latency: VALID rises DEB_CYCLES+3 clocks (+/-1) after a clean KEY rising edge at the pins.
REQ-022 A and B shall never change while VALID=1, except on the edge that clears VALID.
REQ-023 A press pulse shall be consumed in exactly one state; holding KEY shall not auto-repeat.
REQ-024 All arithmetic is unsigned: the debounce counter is $clog2(DEB_CYCLES+1) bits and saturates; the D comparison is a 4-bit unsigned compare.

Reset
REQ-025 While RST_N=0, all of the following shall hold asynchronously: A=0, B=0, VALID=0, ERR=0, STATE=WAIT_A, debounced level=0, counter=0, synchronizer=0.
REQ-026 Release of RST_N shall take effect on a CLK edge; a KEY held high through release shall produce a press only after DEB_CYCLES stable clocks.
REQ-027 A reset asserted mid-debounce or mid-sequence shall discard partial operands; no press pulse is generated across reset.

Structure
REQ-028 Package cyq_loader_pkg shall hold the state enum (WAIT_A, WAIT_B, READY) and the default constants for DEB_CYCLES and MAXCODE.
REQ-029 Sub-module cyq_debounce (synchronizer, counter, edge pulse; parameter DEB_CYCLES; ports CLK, RST_N, KEY, PRESS) shall be instantiated once.
REQ-030 The top level shall contain only the FSM, the operand registers and the output flops; target size is 120-400 lines.

Verification (DEB_CYCLES=4 in simulation)
REQ-031 Reset, then clean press with D=3, clean press with D=7 -> A=3, B=7, VALID=1, STATE=10, ERR=0.
REQ-032 KEY toggled every 2 clocks for 20 clocks with D=5 -> no capture; A=0, STATE=00.
REQ-033 In WAIT_A, press with D=12 -> ERR=1, STATE=00, A=0; then press with D=2 -> ERR=0, A=2, STATE=01.
REQ-034 In READY (A=3, B=7), press with D=9 -> A=9, B=7, VALID=0, STATE=01.
REQ-035 KEY held high for 100 clocks in WAIT_A with D=4 -> exactly one capture; STATE=01.
REQ-036 RST_N pulsed low during WAIT_B -> all outputs return to their REQ-025 values immediately, with no CLK edge needed.
